accu_split: RTL and testbench
=============================

ACCU_SPLIT -- requirements
Module: accu_split

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  10  accumulated word to be split into 8 samples.
REQ-005 valid_in  input  1  data_in valid; transfer occurs when valid_in && ready_in at a rising edge.
REQ-006 ready_in  output  1  block can accept a new word.
REQ-007 data_out  output  8  current sample.
REQ-008 valid_out  output  1  data_out valid; beat completes when valid_out && ready_out at a rising edge.
REQ-009 ready_out  input  1  downstream can accept a sample.
REQ-010 last_out  output  1  high with the 8th (final) sample of a word.
REQ-011 busy  output  1  high while a word is being emitted.

Function
REQ-012 The block SHALL be the inverse of the 8-sample accumulator: one 10-bit word in, eight 8-bit samples out, whose unsigned sum equals data_in exactly.
REQ-013 States SHALL be IDLE and EMIT; ready_in = 1 only in IDLE; busy = 1 only in EMIT.
REQ-014 IDLE -> EMIT on valid_in && ready_in: latch q = data_in[9:3], r = data_in[2:0], beat counter = 0.
REQ-015 valid_in while not ready_in SHALL be ignored; nothing is latched.
REQ-016 In EMIT, data_out SHALL equal q + 1 when beat < r, else q (zero-extended to 8 bits; max value 128, no overflow).
REQ-017 All outputs SHALL be registered; valid_out rises in the cycle after the accepting edge (1-cycle latency).
REQ-018 While valid_out && !ready_out, data_out, last_out and the beat counter SHALL hold stable.
REQ-019 On each completed beat, the beat counter SHALL increment; last_out = 1 exactly when beat == 7.
REQ-020 Completion of beat 7 SHALL return to IDLE and deassert valid_out, last_out and busy in the following cycle.
REQ-021 ready_in SHALL be 1 in the cycle after the final beat, so consecutive words have exactly one idle cycle between them.
REQ-022 The beat counter SHALL be 3 bits and wrap from 7 to 0 only on leaving EMIT.
REQ-023 ready_out has no effect in IDLE; valid_out SHALL never assert in IDLE.

Reset
REQ-024 rst high SHALL immediately force state = IDLE, beat counter = 0, q = 0, r = 0.
REQ-025 During reset: data_out = 0, valid_out = 0, last_out = 0, busy = 0, ready_in = 0.
REQ-026 ready_in SHALL rise on the first clock edge after rst deasserts.
REQ-027 rst asserted mid-burst SHALL abort the word; its remaining samples are never emitted.

Verification
REQ-028 data_in = 1023, ready_out = 1 -> samples 128 x7 then 127; last_out only on the 8th; sum 1023.
REQ-029 data_in = 0 -> eight samples of 0; last_out on the 8th; ready_in returns 1 one cycle later.
REQ-030 data_in = 13 -> samples 2,2,2,2,2,1,1,1.
REQ-031 data_in = 13 with ready_out low for 3 cycles at beat 2 -> data_out holds 2 and valid_out holds 1 for those cycles; the sequence then resumes unchanged.
REQ-032 Second valid_in word presented during EMIT -> it is not consumed, and ready_in stays 0 until one cycle after the first word's last beat.
REQ-033 rst pulse at beat 4 -> valid_out = 0 and busy = 0 immediately; after release a new word of 100 -> 13,13,13,13,12,12,12,12.

Source files
------------

// File: rtl/accu_split.sv
// Splits one 10-bit accumulated word into eight 8-bit samples whose unsigned sum
// equals the word; valid/ready on both sides, all outputs registered.
`timescale 1ns/1ps
module accu_split (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] data_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       last_out,
    output logic       busy
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      r_state;
    logic [6:0]  r_q;
    logic [2:0]  r_r;
    logic [2:0]  r_beat;
    logic [7:0]  r_data_out;
    logic        r_valid_out;
    logic        r_last_out;
    logic        r_busy;
    logic        r_ready_in;
    logic [2:0]  w_beat_next;
    logic        w_accept;
    logic        w_beat_done;

    // The remainder r is spread as +1 over the first r beats.
    function automatic logic [7:0] sample_f(input logic [6:0] q, input logic [2:0] r,
                                            input logic [2:0] beat);
        return {1'b0, q} + ((beat < r) ? 8'd1 : 8'd0);
    endfunction

    assign w_beat_next = r_beat + 3'd1;
    assign w_accept    = valid_in && r_ready_in;
    assign w_beat_done = r_valid_out && ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_r         <= '0;
            r_beat      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            r_busy      <= 1'b0;
            r_ready_in  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            r_busy      <= 1'b0;
            r_ready_in  <= 1'b1;
            if (w_accept) begin
                r_q         <= data_in[9:3];
                r_r         <= data_in[2:0];
                r_beat      <= 3'd0;
                r_data_out  <= sample_f(data_in[9:3], data_in[2:0], 3'd0);
                r_valid_out <= 1'b1;
                r_busy      <= 1'b1;
                r_ready_in  <= 1'b0;
                r_state     <= EMIT;
            end
        end else if (w_beat_done) begin
            if (r_last_out) begin
                r_state     <= IDLE;
                r_beat      <= 3'd0;
                r_data_out  <= '0;
                r_valid_out <= 1'b0;
                r_last_out  <= 1'b0;
                r_busy      <= 1'b0;
                r_ready_in  <= 1'b1;
            end else begin
                r_beat     <= w_beat_next;
                r_data_out <= sample_f(r_q, r_r, w_beat_next);
                r_last_out <= (w_beat_next == 3'd7);
            end
        end
    end

    assign ready_in  = r_ready_in;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign last_out  = r_last_out;
    assign busy      = r_busy;

endmodule

// File: tb/tb_accu_split.sv
// Bench for accu_split: table of words with expected sample runs, scoreboard
// queue checked by a monitor, plus hand sequences for stall, overlap and reset.
`timescale 1ns/1ps
module tb_accu_split;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out;
    logic       last_out;
    logic       busy;

    accu_split dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_out  (last_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]       din;
        logic [0:7][7:0]  exp;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic [9:0] word;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   beats_seen = 0;
    int   acc_sum = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent formulation: sample i = floor((word + 7 - i) / 8).
    function automatic logic [0:7][7:0] model(input logic [9:0] d);
        logic [0:7][7:0] e;
        for (int i = 0; i < 8; i++) e[i] = 8'((int'(d) + 7 - i) / 8);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) chk("busy_with_valid", busy, 1);
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0d, expected no beat", data_out);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sample", data_out, e.d);
                    chk("last", last_out, e.last);
                    acc_sum += data_out;
                    beats_seen++;
                    if (e.last) begin
                        chk("word_sum", acc_sum, e.word);
                        acc_sum = 0;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [9:0] d, input logic [0:7][7:0] exp);
        int n = 0;
        while (!ready_in && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL ready_in_timeout: got 0, expected 1 within 100 cycles");
            return;
        end
        data_in  = d;
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back('{d: exp[i], last: (i == 7), word: d});
        @(posedge clk); #2;
        valid_in = 1'b0;
        chk("accept_valid_out", valid_out, 1);
        chk("accept_ready_in", ready_in, 0);
    endtask

    task automatic drain(input bit bp);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            ready_out = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #2;
            n++;
        end
        ready_out = 1'b1;
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_last(input string name);
        int n = 0;
        while (!(valid_out && ready_out && last_out) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (!(valid_out && last_out)) begin
            checks++;
            errors++;
            $display("FAIL %s: got no last beat, expected one within 100 cycles", name);
        end
    endtask

    initial begin
        tbl[0] = '{10'd1023, {8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd127}};
        tbl[1] = '{10'd0,    {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        tbl[2] = '{10'd13,   {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1}};
        tbl[3] = '{10'd100,  {8'd13, 8'd13, 8'd13, 8'd13, 8'd12, 8'd12, 8'd12, 8'd12}};
        tbl[4] = '{10'd8,    {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}};
        tbl[5] = '{10'd7,    {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0}};
        tbl[6] = '{10'd1016, {8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127}};
        tbl[7] = '{10'd1,    {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};

        rst = 1'b1; data_in = '0; valid_in = 1'b0; ready_out = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready_in", ready_in, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_last_out", last_out, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("ready_in_before_edge", ready_in, 0);
        @(posedge clk); #2;
        chk("ready_in_after_release", ready_in, 1);
        chk("idle_valid_out", valid_out, 0);

        for (int t = 0; t < 8; t++) begin
            send_word(tbl[t].din, tbl[t].exp);
            drain(1'b0);
        end

        // Zero word, then the single idle cycle after the final beat.
        send_word(tbl[1].din, tbl[1].exp);
        wait_last("zero_last");
        @(posedge clk); #2;
        chk("post_last_ready_in", ready_in, 1);
        chk("post_last_valid_out", valid_out, 0);
        chk("post_last_busy", busy, 0);
        chk("post_last_last_out", last_out, 0);
        drain(1'b0);

        // Downstream stall while beat 2 of word 13 is presented.
        begin
            int base = beats_seen;
            int n = 0;
            send_word(tbl[2].din, tbl[2].exp);
            while (beats_seen < base + 2 && n < 50) begin
                @(negedge clk); #1;
                n++;
            end
            @(posedge clk); #2;
            ready_out = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); #1;
                chk("stall_valid_out", valid_out, 1);
                chk("stall_data_out", data_out, 2);
                chk("stall_last_out", last_out, 0);
            end
            @(posedge clk); #2;
            ready_out = 1'b1;
            drain(1'b0);
        end

        // A second word offered during emission must wait.
        send_word(tbl[2].din, tbl[2].exp);
        data_in  = 10'd500;
        valid_in = 1'b1;
        begin
            int n = 0;
            @(negedge clk); #1;
            while (!(valid_out && last_out) && n < 50) begin
                chk("busy_ready_in", ready_in, 0);
                @(negedge clk); #1;
                n++;
            end
            valid_in = 1'b0;
        end
        @(posedge clk); #2;
        chk("overlap_ready_in", ready_in, 1);
        chk("overlap_valid_out", valid_out, 0);
        drain(1'b0);

        // Random words under random backpressure.
        for (int k = 0; k < 6; k++) begin
            logic [9:0] d;
            d = 10'($urandom_range(0, 1023));
            send_word(d, model(d));
            drain(1'b1);
        end

        // Reset while beat 4 is presented; the rest of the word is dropped.
        begin
            int base = beats_seen;
            int n = 0;
            send_word(tbl[0].din, tbl[0].exp);
            while (beats_seen < base + 4 && n < 50) begin
                @(negedge clk); #1;
                n++;
            end
            @(posedge clk); #2;
            chk("pre_abort_valid_out", valid_out, 1);
            rst = 1'b1;
            #1;
            chk("abort_valid_out", valid_out, 0);
            chk("abort_busy", busy, 0);
            chk("abort_data_out", data_out, 0);
            sb.delete();
            acc_sum = 0;
            @(posedge clk); #2;
            rst = 1'b0;
            send_word(tbl[3].din, tbl[3].exp);
            drain(1'b0);
        end

        repeat (3) begin
            @(negedge clk); #1;
            chk("final_idle_valid_out", valid_out, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
